sdramtest_uart_report: RTL and testbench
========================================

SDRAMTEST_UART_REPORT -- requirements
Module: sdramtest_uart_report

Interface
- REQ-001 SHALL have parameter SYSCLK_FREQUENCY, default 1000, meaning the clk frequency in units of 100 kHz.
- REQ-002 SHALL have parameter BAUD, default 115200, meaning the UART bit rate in bit/s.
- REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
- REQ-004 SHALL have port reset, input, 1, reset that is asynchronous and active-high.
- REQ-005 SHALL have port evt_stb, input, 1, a one-cycle report request from the tester.
- REQ-006 SHALL have port evt_code, input, 2, the report kind: 0 PASS, 1 FAIL, 2 and 3 reserved.
- REQ-007 SHALL have port evt_data, input, 32, the pass count or failing address/data word.
- REQ-008 SHALL have port busy, output, 1, high while a line or banner is in flight.
- REQ-009 SHALL have port drop_cnt, output, 8, the number of events lost while busy.
- REQ-010 SHALL have port uart_tx, output, 1, the 8N1 serial line.

Function
- REQ-011 SHALL set DIV = SYSCLK_FREQUENCY*100000/BAUD, truncated at elaboration (default 868); every bit SHALL last exactly DIV clk cycles.
- REQ-012 SHALL format each accepted event as 12 ASCII bytes: code char ('P', 'F', '?' for 2/3), space (0x20), evt_data as 8 uppercase hex digits MSB first, CR (0x0D), LF (0x0A).
- REQ-013 SHALL accept evt_stb only when busy=0, latching evt_code and evt_data in that cycle.
- REQ-014 SHALL count evt_stb while busy=1 as a drop, incrementing drop_cnt and saturating at 255 with no wrap.
- REQ-015 SHALL use the states IDLE, LOAD, START, DATA, STOP and NEXT.
- REQ-016 SHALL make these transitions: IDLE->LOAD on accept; LOAD->START; START->DATA after DIV cycles; DATA->STOP after 8 bits, LSB first; STOP->NEXT after DIV cycles; NEXT->LOAD if bytes remain, else IDLE.
- REQ-017 SHALL drive uart_tx low on the first START cycle, which is 2 cycles after the accept cycle N (cycle N+2).
- REQ-018 SHALL leave no idle gap between bytes of one line (NEXT and LOAD are absorbed into the stop bit's final cycles, so the frame period is exactly 10*DIV).
- REQ-019 SHALL hold busy high from cycle N+1 until the cycle after the last stop bit of the line ends.
- REQ-020 SHALL treat an evt_stb in the same cycle busy falls as a drop; evt_stb is accepted only when registered busy=0.
- REQ-021 SHALL hold uart_tx high in IDLE and during the STOP bit.

Reset
- REQ-022 SHALL reset asynchronously, giving uart_tx=1, busy=0, drop_cnt=0, state IDLE, and byte index and bit counters 0.
- REQ-023 SHALL abort any frame in progress on reset assertion mid-line, with uart_tx returning high immediately and no partial-line resume after release.
- REQ-024 SHALL not treat a dropped event as a reset or status change; drop_cnt is cleared only by reset.

Configuration
- REQ-025 SHALL support macro SDRAMTEST_UART_BANNER_EN.
- REQ-026 SHALL, when SDRAMTEST_UART_BANNER_EN is defined, send "SDRAM\r\n" (7 bytes) automatically after reset release, with busy=1 throughout and evt_stb treated as a drop during it.
- REQ-027 SHALL, when SDRAMTEST_UART_BANNER_EN is undefined, have no banner ROM and remain in IDLE after reset.

Structure
- REQ-028 SHALL place the following in package sdramtest_pkg: evt_code enum (EVT_PASS, EVT_FAIL), state enum, LINE_LEN=12, BANNER_LEN=7, and the ASCII constants (CR, LF, SPACE).
- REQ-029 SHALL keep the hex-nibble-to-ASCII function in sdramtest_pkg.
- REQ-030 SHALL contain one sub-module, uart_tx_8n1 (bit timer, shift register, ready/strobe handshake); the line formatter and drop counter stay in the parent.

Verification (SYSCLK_FREQUENCY=1, BAUD=10000 -> DIV=10, banner off unless stated)
- REQ-031 SHALL cover: PASS, evt_data=0x0000002A at cycle N -> start bit at N+2, bytes 50 20 30 30 30 30 30 30 32 41 0D 0A, busy low at N+2+1200.
- REQ-032 SHALL cover: FAIL, evt_data=0xDEADBEEF -> 46 20 44 45 41 44 42 45 45 46 0D 0A, each bit exactly 10 cycles.
- REQ-033 SHALL cover: 300 evt_stb pulses while busy -> drop_cnt=255 and the original line unchanged.
- REQ-034 SHALL cover: reset asserted during byte 5 of a line -> uart_tx=1 that cycle, busy=0, and a new event after release is sent in full.
- REQ-035 SHALL cover: banner macro defined -> 53 44 52 41 4D 0D 0A starting at reset release + 2, and evt_stb at +50 raising drop_cnt to 1.
- REQ-036 SHALL cover: evt_code=3 -> first byte 3F.

Source files
------------

// File: rtl/sdramtest_pkg.sv
// Shared types, constants and helpers for the SDRAM tester UART reporter.
package sdramtest_pkg;

  typedef enum logic [1:0] {
    EVT_PASS = 2'd0,
    EVT_FAIL = 2'd1
  } evt_code_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP,
    NEXT
  } state_t;

  localparam int LINE_LEN   = 12;
  localparam int BANNER_LEN = 7;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SPACE = 8'h20;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'd0, nib}) : (8'h37 + {4'd0, nib});
  endfunction

endpackage

// File: rtl/sdramtest_uart_report_uart_tx_8n1.sv
// 8N1 byte transmitter. A line is started with go while ready; each byte is
// fetched from data in LOAD and byte_done pulses in NEXT. STOP is shortened
// by two cycles so that NEXT and LOAD fill out the stop bit, keeping the
// frame period at exactly 10*DIV with back-to-back bytes.
module uart_tx_8n1
  import sdramtest_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] data,
  input  logic       last,
  output logic       ready,
  output logic       byte_done,
  output logic       tx
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_END = CW'(DIV - 3);

  state_t          state_reg, state_next;
  logic [CW-1:0]   tick_reg, tick_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;

  // State, bit timer, bit counter and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic: start bit, 8 data bits LSB first, shortened stop bit.
  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    case (state_reg)
      IDLE: if (go) state_next = LOAD;
      LOAD: begin
        shift_next = data;
        tick_next  = '0;
        bit_next   = '0;
        state_next = START;
      end
      START: begin
        if (tick_reg == BIT_END) begin
          tick_next  = '0;
          state_next = DATA;
        end else begin
          tick_next = tick_reg + CW'(1);
        end
      end
      DATA: begin
        if (tick_reg == BIT_END) begin
          tick_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end else begin
          tick_next = tick_reg + CW'(1);
        end
      end
      STOP: begin
        if (tick_reg == STOP_END) begin
          tick_next  = '0;
          state_next = NEXT;
        end else begin
          tick_next = tick_reg + CW'(1);
        end
      end
      NEXT: state_next = last ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  assign ready     = (state_reg == IDLE);
  assign byte_done = (state_reg == NEXT);
  assign tx        = (state_reg == START) ? 1'b0 :
                     (state_reg == DATA)  ? shift_reg[0] : 1'b1;

endmodule

// File: rtl/sdramtest_uart_report.sv
// SDRAM tester report formatter: turns PASS/FAIL events into 12-byte ASCII
// lines on an 8N1 UART and counts events that arrive while busy.
// Optional feature macro: SDRAMTEST_UART_BANNER_EN sends "SDRAM\r\n" after
// every reset release.
module sdramtest_uart_report
  import sdramtest_pkg::*;
#(
  parameter int SYSCLK_FREQUENCY = 1000,
  parameter int BAUD             = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        evt_stb,
  input  logic [1:0]  evt_code,
  input  logic [31:0] evt_data,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output logic        uart_tx
);

  localparam int DIV = SYSCLK_FREQUENCY * 100000 / BAUD;

  logic        busy_reg;
  logic [7:0]  drop_reg;
  logic [1:0]  code_reg;
  logic [31:0] data_reg;
  logic [3:0]  idx_reg;
  logic        accept, drop, go, ready, byte_done, last_byte;
  logic        banner_pend, banner_line;
  logic [7:0]  line_byte, banner_byte, tx_byte;
  logic [3:0]  nibbles [8];

`ifdef SDRAMTEST_UART_BANNER_EN
  logic banner_pend_reg, banner_line_reg;

  // Banner is armed by reset and launched on the first clock after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      banner_pend_reg <= 1'b1;
      banner_line_reg <= 1'b0;
    end else if (banner_pend_reg) begin
      banner_pend_reg <= 1'b0;
      banner_line_reg <= 1'b1;
    end else if (accept) begin
      banner_line_reg <= 1'b0;
    end
  end

  function automatic logic [7:0] banner_rom(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h53;
      4'd1:    return 8'h44;
      4'd2:    return 8'h52;
      4'd3:    return 8'h41;
      4'd4:    return 8'h4D;
      4'd5:    return CR;
      default: return LF;
    endcase
  endfunction

  assign banner_pend = banner_pend_reg;
  assign banner_line = banner_line_reg;
  assign banner_byte = banner_rom(idx_reg);
`else
  assign banner_pend = 1'b0;
  assign banner_line = 1'b0;
  assign banner_byte = 8'h00;
`endif

  // Events are taken only while the registered busy is low; the pending
  // banner has priority and turns a coincident event into a drop.
  assign accept = evt_stb & ~busy_reg & ~banner_pend;
  assign drop   = evt_stb & (busy_reg | banner_pend);
  assign go     = accept | banner_pend;

  // Event latch, busy flag, byte index and saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg <= 1'b0;
      drop_reg <= 8'd0;
      code_reg <= 2'd0;
      data_reg <= 32'd0;
      idx_reg  <= 4'd0;
    end else begin
      if (accept) begin
        code_reg <= evt_code;
        data_reg <= evt_data;
      end
      if (go) busy_reg <= 1'b1;
      else if (ready && busy_reg) busy_reg <= 1'b0;
      if (go) idx_reg <= 4'd0;
      else if (byte_done) idx_reg <= idx_reg + 4'd1;
      if (drop && drop_reg != 8'hFF) drop_reg <= drop_reg + 8'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nib
      assign nibbles[gi] = data_reg[31 - 4*gi -: 4];
    end
  endgenerate

  // Line formatter: code char, space, 8 hex digits MSB first, CR, LF.
  always_comb begin
    line_byte = hex_ascii(nibbles[3'(idx_reg - 4'd2)]);
    case (idx_reg)
      4'd0: begin
        case (code_reg)
          EVT_PASS: line_byte = 8'h50;
          EVT_FAIL: line_byte = 8'h46;
          default:  line_byte = 8'h3F;
        endcase
      end
      4'd1:    line_byte = SPACE;
      4'd10:   line_byte = CR;
      4'd11:   line_byte = LF;
      default: ;
    endcase
  end

  assign tx_byte   = banner_line ? banner_byte : line_byte;
  assign last_byte = banner_line ? (idx_reg == 4'(BANNER_LEN - 1))
                                 : (idx_reg == 4'(LINE_LEN - 1));

  uart_tx_8n1 #(.DIV(DIV)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .data      (tx_byte),
    .last      (last_byte),
    .ready     (ready),
    .byte_done (byte_done),
    .tx        (uart_tx)
  );

  assign busy     = busy_reg;
  assign drop_cnt = drop_reg;

endmodule

// File: tb/tb_sdramtest_uart_report.sv
// Scoreboard bench for sdramtest_uart_report at DIV=10. Stimulus pushes the
// expected bytes and their start-bit cycles; a UART monitor decodes frames.
module tb_sdramtest_uart_report;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        evt_stb = 1'b0;
  logic [1:0]  evt_code = 2'd0;
  logic [31:0] evt_data = 32'd0;
  logic        busy, uart_tx;
  logic [7:0]  drop_cnt;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int exp_drop = 0;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;
  exp_t exp_q[$];

  sdramtest_uart_report #(.SYSCLK_FREQUENCY(1), .BAUD(10000)) dut (
    .clk      (clk),
    .reset    (reset),
    .evt_stb  (evt_stb),
    .evt_code (evt_code),
    .evt_data (evt_data),
    .busy     (busy),
    .drop_cnt (drop_cnt),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input int start);
    exp_t e;
    e.b = b;
    e.start = start;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic       mon_active = 1'b0;
  int         mon_start = 0, mon_ph = 0, mon_err = 0;
  logic [7:0] mon_byte = 8'h00, mon_want = 8'h00;
  logic       want_bit;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx == 1'b0) begin
        mon_active = 1'b1;
        mon_start  = cyc;
        mon_ph     = 0;
        mon_err    = 0;
        mon_byte   = 8'h00;
        mon_want   = (exp_q.size() > 0) ? exp_q[0].b : 8'h00;
      end
    end else begin
      mon_ph = mon_ph + 1;
      if (mon_ph < 10)      want_bit = 1'b0;
      else if (mon_ph < 90) want_bit = mon_want[(mon_ph - 10) / 10];
      else                  want_bit = 1'b1;
      if (uart_tx !== want_bit) mon_err++;
      if (mon_ph >= 15 && mon_ph < 90 && (mon_ph % 10) == 5)
        mon_byte[(mon_ph - 15) / 10] = uart_tx;
      if (mon_ph == 95) begin
        mon_active = 1'b0;
        check("byte_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          $display("byte %02h start cycle %0d (want %02h at %0d)", mon_byte, mon_start, mon_e.b, mon_e.start);
          check("byte_value", mon_byte, mon_e.b);
          check("byte_start", mon_start, mon_e.start);
          check("bit_timing", mon_err, 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check("idle_timeout", busy, 0);
  endtask

  task automatic issue_line(input logic [1:0] code, input logic [31:0] data,
                            input logic [95:0] bytes, output int n);
    wait_idle();
    @(negedge clk);
    evt_stb = 1'b1;
    evt_code = code;
    evt_data = data;
    n = cyc;
    for (int k = 0; k < 12; k++) push_byte(bytes[95 - 8*k -: 8], n + 2 + 100*k);
    @(negedge clk);
    evt_stb = 1'b0;
    evt_data = 32'd0;
    check("busy_rise", busy, 1);
  endtask

  task automatic finish_line(input int n, input bit stb_at_fall);
    while (cyc < n + 1201) @(negedge clk);
    check("busy_last", busy, 1);
    if (stb_at_fall) begin
      evt_stb = 1'b1;
      evt_data = 32'h5555AAAA;
      if (exp_drop < 255) exp_drop++;
    end
    @(negedge clk);
    evt_stb = 1'b0;
    check("busy_fall", busy, 0);
    check("drop_after_line", drop_cnt, exp_drop);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic release_reset();
    int r;
    @(negedge clk);
    reset = 1'b0;
    r = cyc;
`ifdef SDRAMTEST_UART_BANNER_EN
    begin
      logic [55:0] bn;
      bn = 56'h53_44_52_41_4D_0D_0A;
      for (int k = 0; k < 7; k++) push_byte(bn[55 - 8*k -: 8], r + 2 + 100*k);
      while (cyc < r + 50) @(negedge clk);
      evt_stb = 1'b1;
      evt_data = 32'hBAD0BAD0;
      @(negedge clk);
      evt_stb = 1'b0;
      exp_drop++;
      check("banner_drop", drop_cnt, exp_drop);
      while (cyc < r + 701) @(negedge clk);
      check("banner_busy_last", busy, 1);
      @(negedge clk);
      check("banner_busy_fall", busy, 0);
      check("banner_drained", exp_q.size(), 0);
    end
`else
    repeat (30) @(negedge clk);
    check("no_banner_busy", busy, 0);
    check("no_banner_tx", uart_tx, 1);
`endif
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_tx", uart_tx, 1);
    check("reset_busy", busy, 0);
    check("reset_drop", drop_cnt, 0);
    release_reset();

    // PASS 0x2A, with an event in the cycle busy falls (must be a drop)
    issue_line(2'd0, 32'h0000002A, 96'h50_20_30_30_30_30_30_30_32_41_0D_0A, n);
    finish_line(n, 1'b1);

    // FAIL 0xDEADBEEF
    issue_line(2'd1, 32'hDEADBEEF, 96'h46_20_44_45_41_44_42_45_45_46_0D_0A, n);
    finish_line(n, 1'b0);

    // reserved code 3
    issue_line(2'd3, 32'h01234567, 96'h3F_20_30_31_32_33_34_35_36_37_0D_0A, n);
    finish_line(n, 1'b0);

    // reserved code 2 with 300 events while busy -> saturate at 255
    issue_line(2'd2, 32'h89ABCDEF, 96'h3F_20_38_39_41_42_43_44_45_46_0D_0A, n);
    for (int k = 0; k < 300; k++) begin
      evt_stb = 1'b1;
      evt_code = 2'(k);
      evt_data = $urandom;
      @(negedge clk);
    end
    evt_stb = 1'b0;
    exp_drop = 255;
    check("drop_saturate", drop_cnt, exp_drop);
    finish_line(n, 1'b0);

    // PASS all-F, one more drop must not wrap
    issue_line(2'd0, 32'hFFFFFFFF, 96'h50_20_46_46_46_46_46_46_46_46_0D_0A, n);
    evt_stb = 1'b1;
    @(negedge clk);
    evt_stb = 1'b0;
    check("drop_no_wrap", drop_cnt, 255);
    finish_line(n, 1'b0);

    // reset in the middle of byte 5
    issue_line(2'd1, 32'h12345678, 96'h46_20_31_32_33_34_35_36_37_38_0D_0A, n);
    while (cyc < n + 532) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_tx", uart_tx, 1);
    check("abort_busy", busy, 0);
    check("abort_drop", drop_cnt, 0);
    exp_q.delete();
    exp_drop = 0;
    repeat (3) @(negedge clk);
    release_reset();

    // new line after reset goes out in full
    issue_line(2'd1, 32'h00C0FFEE, 96'h46_20_30_30_43_30_46_46_45_45_0D_0A, n);
    finish_line(n, 1'b0);

    repeat (50) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
